// File: rtl/ntt_pkg.sv
// ============================================================================
// Module      : ntt_pkg
// Description : Shared defaults and clear-engine state encoding for the NTT
//               polynomial bank RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ntt_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 256;
    localparam int DEF_BANKS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

endpackage

`default_nettype wire

// File: rtl/ntt_ram_clr.sv
// ============================================================================
// Module      : ntt_ram_clr
// Description : Clear engine. Sweeps the flat RAM two words per cycle and
//               reports busy / clr_done. Reset starts a sweep from zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ntt_ram_clr
    import ntt_pkg::*;
#(
    parameter int WORDS = DEF_BANKS * DEF_DEPTH,
    parameter int CW    = $clog2(WORDS / 2)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_start,
    output logic        busy,
    output logic        clr_done,
    output logic [CW:0] wr_addr_a,
    output logic [CW:0] wr_addr_b
);

    localparam logic [CW-1:0] c_last_pair = CW'(WORDS / 2 - 1);

    clr_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Counter parks on the final pair so the sweep never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == c_last_pair) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == CLEAR);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign clr_done  = done_q;
    assign wr_addr_a = {cnt_q, 1'b0};
    assign wr_addr_b = {cnt_q, 1'b1};

endmodule

`default_nettype wire

// File: rtl/ntt_bank_ram.sv
// ============================================================================
// Module      : ntt_bank_ram
// Description : Dual-port banked polynomial RAM with automatic zeroing engine.
//               Optional write-to-read forwarding when NTT_RAM_FWD_EN is
//               defined; otherwise reads are read-first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ntt_bank_ram
    import ntt_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int BANKS = DEF_BANKS,
    parameter int AW    = $clog2(DEPTH),
    parameter int BW    = $clog2(BANKS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_start,
    output logic             busy,
    output logic             clr_done,
    input  logic             en_a,
    input  logic             we_a,
    input  logic [BW-1:0]    wbank_a,
    input  logic [AW-1:0]    waddr_a,
    input  logic [BW-1:0]    rbank_a,
    input  logic [AW-1:0]    raddr_a,
    input  logic [WIDTH-1:0] din_a,
    output logic [WIDTH-1:0] dout_a,
    output logic             dvalid_a,
    input  logic             en_b,
    input  logic             we_b,
    input  logic [BW-1:0]    wbank_b,
    input  logic [AW-1:0]    waddr_b,
    input  logic [BW-1:0]    rbank_b,
    input  logic [AW-1:0]    raddr_b,
    input  logic [WIDTH-1:0] din_b,
    output logic [WIDTH-1:0] dout_b,
    output logic             dvalid_b,
    output logic             collision_o
);

    localparam int FW  = BW + AW;
    localparam int CCW = $clog2(BANKS * DEPTH / 2);

    logic [WIDTH-1:0] mem [BANKS*DEPTH];

    logic [CCW:0]     w_clr_wa_a, w_clr_wa_b;
    logic             w_busy;

    logic             w_rd_a, w_rd_b, w_wr_a, w_wr_b;
    logic [FW-1:0]    w_ext_wa_a, w_ext_wa_b, w_ra_a, w_ra_b;
    logic             w_mem_we_a, w_mem_we_b;
    logic [FW-1:0]    w_mem_wa_a, w_mem_wa_b;
    logic [WIDTH-1:0] w_mem_wd_a, w_mem_wd_b;
    logic [WIDTH-1:0] w_rdata_a, w_rdata_b;

    logic [WIDTH-1:0] dout_a_q, dout_a_d, dout_b_q, dout_b_d;
    logic             dvalid_a_q, dvalid_a_d, dvalid_b_q, dvalid_b_d;
    logic             collision_q, collision_d;

    ntt_ram_clr #(
        .WORDS (BANKS * DEPTH),
        .CW    (CCW)
    ) u_clr (
        .clk       (clk),
        .rst       (rst),
        .clr_start (clr_start),
        .busy      (w_busy),
        .clr_done  (clr_done),
        .wr_addr_a (w_clr_wa_a),
        .wr_addr_b (w_clr_wa_b)
    );

    assign busy = w_busy;

    assign w_rd_a     = en_a & ~w_busy;
    assign w_rd_b     = en_b & ~w_busy;
    assign w_wr_a     = w_rd_a & we_a;
    assign w_wr_b     = w_rd_b & we_b;
    assign w_ext_wa_a = {wbank_a, waddr_a};
    assign w_ext_wa_b = {wbank_b, waddr_b};
    assign w_ra_a     = {rbank_a, raddr_a};
    assign w_ra_b     = {rbank_b, raddr_b};

    // While clearing, the engine owns both write ports and writes zeros.
    assign w_mem_we_a = w_busy | w_wr_a;
    assign w_mem_we_b = w_busy | w_wr_b;
    assign w_mem_wa_a = w_busy ? FW'(w_clr_wa_a) : w_ext_wa_a;
    assign w_mem_wa_b = w_busy ? FW'(w_clr_wa_b) : w_ext_wa_b;
    assign w_mem_wd_a = w_busy ? '0 : din_a;
    assign w_mem_wd_b = w_busy ? '0 : din_b;

    // Port B is applied last so it wins a same-address double write.
    always_ff @(posedge clk) begin
        if (w_mem_we_a) mem[w_mem_wa_a] <= w_mem_wd_a;
        if (w_mem_we_b) mem[w_mem_wa_b] <= w_mem_wd_b;
    end

`ifdef NTT_RAM_FWD_EN
    always_comb begin
        w_rdata_a = mem[w_ra_a];
        if (w_wr_b && (w_ext_wa_b == w_ra_a)) begin
            w_rdata_a = din_b;
        end else if (w_wr_a && (w_ext_wa_a == w_ra_a)) begin
            w_rdata_a = din_a;
        end
        w_rdata_b = mem[w_ra_b];
        if (w_wr_b && (w_ext_wa_b == w_ra_b)) begin
            w_rdata_b = din_b;
        end else if (w_wr_a && (w_ext_wa_a == w_ra_b)) begin
            w_rdata_b = din_a;
        end
    end
`else
    assign w_rdata_a = mem[w_ra_a];
    assign w_rdata_b = mem[w_ra_b];
`endif

    always_comb begin
        dout_a_d    = w_rd_a ? w_rdata_a : dout_a_q;
        dout_b_d    = w_rd_b ? w_rdata_b : dout_b_q;
        dvalid_a_d  = w_rd_a;
        dvalid_b_d  = w_rd_b;
        collision_d = w_wr_a & w_wr_b & (w_ext_wa_a == w_ext_wa_b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_a_q    <= '0;
            dout_b_q    <= '0;
            dvalid_a_q  <= 1'b0;
            dvalid_b_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            dout_a_q    <= dout_a_d;
            dout_b_q    <= dout_b_d;
            dvalid_a_q  <= dvalid_a_d;
            dvalid_b_q  <= dvalid_b_d;
            collision_q <= collision_d;
        end
    end

    assign dout_a      = dout_a_q;
    assign dout_b      = dout_b_q;
    assign dvalid_a    = dvalid_a_q;
    assign dvalid_b    = dvalid_b_q;
    assign collision_o = collision_q;

endmodule

`default_nettype wire

// File: tb/tb_ntt_bank_ram.sv
// ============================================================================
// Module      : tb_ntt_bank_ram
// Description : Directed self-checking bench for ntt_bank_ram (default
//               parameters; forwarding expectations follow NTT_RAM_FWD_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ntt_bank_ram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr_start = 1'b0;
    logic        busy, clr_done;
    logic        en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
    logic [0:0]  wbank_a = '0, rbank_a = '0, wbank_b = '0, rbank_b = '0;
    logic [7:0]  waddr_a = '0, raddr_a = '0, waddr_b = '0, raddr_b = '0;
    logic [31:0] din_a = '0, din_b = '0;
    logic [31:0] dout_a, dout_b;
    logic        dvalid_a, dvalid_b, collision_o;

    int n_checks = 0;
    int n_errors = 0;
    int n_busy;
    int n_done;

    ntt_bank_ram dut (
        .clk         (clk),
        .rst         (rst),
        .clr_start   (clr_start),
        .busy        (busy),
        .clr_done    (clr_done),
        .en_a        (en_a),
        .we_a        (we_a),
        .wbank_a     (wbank_a),
        .waddr_a     (waddr_a),
        .rbank_a     (rbank_a),
        .raddr_a     (raddr_a),
        .din_a       (din_a),
        .dout_a      (dout_a),
        .dvalid_a    (dvalid_a),
        .en_b        (en_b),
        .we_b        (we_b),
        .wbank_b     (wbank_b),
        .waddr_b     (waddr_b),
        .rbank_b     (rbank_b),
        .raddr_b     (raddr_b),
        .din_b       (din_b),
        .dout_b      (dout_b),
        .dvalid_b    (dvalid_b),
        .collision_o (collision_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en_a = 1'b0; we_a = 1'b0;
        en_b = 1'b0; we_b = 1'b0;
    endtask

    task automatic set_a(input logic we, input logic [0:0] wb, input logic [7:0] wa,
                         input logic [31:0] d, input logic [0:0] rb, input logic [7:0] ra);
        en_a = 1'b1; we_a = we; wbank_a = wb; waddr_a = wa; din_a = d;
        rbank_a = rb; raddr_a = ra;
    endtask

    task automatic set_b(input logic we, input logic [0:0] wb, input logic [7:0] wa,
                         input logic [31:0] d, input logic [0:0] rb, input logic [7:0] ra);
        en_b = 1'b1; we_b = we; wbank_b = wb; waddr_b = wa; din_b = d;
        rbank_b = rb; raddr_b = ra;
    endtask

    // Counts cycles with busy high (bounded) and clr_done pulses seen.
    task automatic wait_clear();
        n_busy = 0;
        n_done = 0;
        while (busy && n_busy < 1000) begin
            n_busy++;
            tick();
            idle();
            if (clr_done) n_done++;
        end
        tick();
        if (clr_done) n_done++;
    endtask

    initial begin
        tick();
        rst = 1'b0;
        check_eq("rst_busy",      32'(busy),        32'd1);
        check_eq("rst_dout_a",    dout_a,           32'd0);
        check_eq("rst_dout_b",    dout_b,           32'd0);
        check_eq("rst_dvalid",    32'({dvalid_a, dvalid_b}), 32'd0);
        check_eq("rst_flags",     32'({clr_done, collision_o}), 32'd0);

        wait_clear();
        check_eq("boot_busy_len", 32'(n_busy), 32'd256);
        check_eq("boot_done_cnt", 32'(n_done), 32'd1);

        set_a(1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 8'd129);
        tick(); idle();
        check_eq("boot_rd_dout",   dout_a,         32'd0);
        check_eq("boot_rd_dvalid", 32'(dvalid_a),  32'd1);

        set_a(1'b1, 1'b0, 8'd0,   32'd16, 1'b0, 8'd0);
        set_b(1'b1, 1'b1, 8'd128, 32'd3,  1'b0, 8'd0);
        tick(); idle();
        check_eq("wr_no_coll", 32'(collision_o), 32'd0);
        set_a(1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 8'd0);
        set_b(1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 8'd128);
        tick(); idle();
        check_eq("rd_a_16",  dout_a, 32'd16);
        check_eq("rd_b_3",   dout_b, 32'd3);
        check_eq("rd_valid", 32'({dvalid_a, dvalid_b}), 32'd3);
        tick();
        check_eq("hold_dout_a",  dout_a, 32'd16);
        check_eq("idle_dvalid",  32'({dvalid_a, dvalid_b}), 32'd0);

        set_a(1'b1, 1'b0, 8'd5, 32'd7, 1'b0, 8'd0);
        set_b(1'b1, 1'b0, 8'd5, 32'd9, 1'b0, 8'd0);
        tick(); idle();
        check_eq("coll_pulse", 32'(collision_o), 32'd1);
        tick();
        check_eq("coll_clear", 32'(collision_o), 32'd0);
        set_a(1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 8'd5);
        tick(); idle();
        check_eq("coll_b_wins", dout_a, 32'd9);

        set_a(1'b1, 1'b0, 8'd1, 32'd20, 1'b0, 8'd0);
        tick(); idle();
        set_a(1'b1, 1'b0, 8'd1, 32'd5, 1'b0, 8'd1);
        set_b(1'b1, 1'b0, 8'd2, 32'h55, 1'b0, 8'd2);
        tick(); idle();
`ifdef NTT_RAM_FWD_EN
        check_eq("rw_same_a", dout_a, 32'd5);
        check_eq("rw_same_b", dout_b, 32'h55);
`else
        check_eq("rw_same_a", dout_a, 32'd20);
        check_eq("rw_same_b", dout_b, 32'd0);
`endif
        set_a(1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 8'd1);
        set_b(1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 8'd2);
        tick(); idle();
        check_eq("after_rw_a", dout_a, 32'd5);
        check_eq("after_rw_b", dout_b, 32'h55);

        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        check_eq("clr_busy", 32'(busy), 32'd1);
        set_a(1'b1, 1'b0, 8'd0, 32'd99, 1'b0, 8'd0);
        set_b(1'b1, 1'b0, 8'd7, 32'd77, 1'b0, 8'd0);
        wait_clear();
        check_eq("clr_busy_len", 32'(n_busy), 32'd256);
        check_eq("clr_done_cnt", 32'(n_done), 32'd1);
        check_eq("busy_rd_ign",  32'({dvalid_a, dvalid_b}), 32'd0);

        set_a(1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 8'd0);
        set_b(1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 8'd128);
        tick(); idle();
        check_eq("clr_a0",   dout_a, 32'd0);
        check_eq("clr_b128", dout_b, 32'd0);
        set_a(1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 8'd5);
        set_b(1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 8'd7);
        tick(); idle();
        check_eq("clr_a5", dout_a, 32'd0);
        check_eq("clr_b7", dout_b, 32'd0);
        set_a(1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 8'd1);
        set_b(1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 8'd2);
        tick(); idle();
        check_eq("clr_a1", dout_a, 32'd0);
        check_eq("clr_b2", dout_b, 32'd0);

        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (100) tick();
        check_eq("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_clear();
        check_eq("rst_mid_len",  32'(n_busy), 32'd256);
        check_eq("rst_mid_done", 32'(n_done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
